tripledes_decrypt_seq: RTL and testbench

Sequential triple-DES decryption engine: the receive-side counterpart of the combinational `tripledes` encryptor. It accepts one 64-bit ciphertext block with valid/ready handshaking and runs three passes through a single shared `des` instance, one pass per clock. It then holds the 64-bit plaintext under a valid/ready output handshake. It sits between the ciphertext source (bus/register interface) and the plaintext consumer, replacing three chained combinational DES cores with one DES core plus a small FSM.

---
 rtl/tripledes_decrypt_seq.sv | 175 +++++++++++++++++
 tb/tb_tripledes_decrypt_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tripledes_decrypt_seq.sv
// Triple-DES decryptor: one shared combinational DES core, three passes per block
// (D(kA), E(k2), D(k1)), with valid/ready handshakes on both sides.

module des (
   output logic [63:0] out,
   input  logic [63:0] in,
   input  logic [63:0] k,
   input  logic        e
);
   // Table entries are 1-based bit numbers with bit 1 as the MSB.
   localparam int IP [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                              62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                              57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3,
                              61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
   localparam int FP [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                              38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                              36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                              34,2,42,10,50,18,58,26, 33,1,41, 9,49,17,57,25};
   localparam int E  [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
   localparam int P  [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
   localparam int PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                               19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                               14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
   localparam int PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                               41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
   // Rounds whose key halves rotate by two instead of one.
   localparam logic [15:0] TWO = 16'h7EFC;
   // Each S-box row packed as 16 nibbles, column 0 in the top nibble.
   localparam logic [63:0] SBOX [8][4] = '{
      '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
      '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
      '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
      '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
      '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
      '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
      '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
      '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}};

   function automatic logic [63:0] des_core(input logic [63:0] blk, input logic [63:0] key,
                                            input logic enc);
      logic [55:0] cd;
      logic [27:0] c, d;
      logic [47:0] ks [16];
      logic [63:0] v, o;
      logic [31:0] l, r, f, s;
      logic [47:0] x;
      logic [5:0]  b;
      for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
      c = cd[55:28];
      d = cd[27:0];
      for (int n = 0; n < 16; n++) begin
         if (TWO[n]) begin
            c = {c[25:0], c[27:26]};
            d = {d[25:0], d[27:26]};
         end else begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
         cd = {c, d};
         for (int i = 0; i < 48; i++) ks[n][47-i] = cd[56-PC2[i]];
      end
      for (int i = 0; i < 64; i++) v[63-i] = blk[64-IP[i]];
      l = v[63:32];
      r = v[31:0];
      // Decryption is the same network with the subkey order reversed.
      for (int n = 0; n < 16; n++) begin
         for (int i = 0; i < 48; i++) x[47-i] = r[32-E[i]];
         x = x ^ (enc ? ks[n] : ks[15-n]);
         for (int j = 0; j < 8; j++) begin
            b = x[47-6*j -: 6];
            s[31-4*j -: 4] = SBOX[j][{b[5], b[0]}][63-4*int'(b[4:1]) -: 4];
         end
         for (int i = 0; i < 32; i++) f[31-i] = s[32-P[i]];
         f = f ^ l;
         l = r;
         r = f;
      end
      v = {r, l};
      for (int i = 0; i < 64; i++) o[63-i] = v[64-FP[i]];
      return o;
   endfunction

   always_comb out = des_core(in, k, e);
endmodule

module tripledes_decrypt_seq #(
   parameter bit THREE_KEY = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] ciphertext,
   input  logic [63:0] key1,
   input  logic [63:0] key2,
   input  logic [63:0] key3,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] plaintext,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state;
   logic [63:0] data, ka, k2, kc;
   logic [1:0]  pass;
   logic [63:0] des_k, des_out;
   logic        des_e;

   // Pass 3 cannot occur; it falls into the pass-2 selection.
   always_comb begin
      des_k = kc;
      des_e = 1'b0;
      case (pass)
         2'd0:    des_k = ka;
         2'd1:    begin des_k = k2; des_e = 1'b1; end
         default: ;
      endcase
   end

   des u_des (.out(des_out), .in(data), .k(des_k), .e(des_e));

   assign plaintext = data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pass      <= 2'd0;
         data      <= '0;
         ka        <= '0;
         k2        <= '0;
         kc        <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               data     <= ciphertext;
               ka       <= THREE_KEY ? key3 : key1;
               k2       <= key2;
               kc       <= key1;
               pass     <= 2'd0;
               state    <= RUN;
               in_ready <= 1'b0;
               busy     <= 1'b1;
            end
            RUN: begin
               data <= des_out;
               pass <= pass + 2'd1;
               if (pass >= 2'd2) begin
                  pass      <= 2'd0;
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: if (out_ready) begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               pass      <= 2'd0;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_tripledes_decrypt_seq.sv
// Bench for tripledes_decrypt_seq: both keying options side by side, checked against
// a FIPS-table DES model, known-answer vectors, backpressure, churn and reset abort.

module tb_tripledes_decrypt_seq;
   logic        clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
   logic [63:0] ciphertext = '0, key1 = '0, key2 = '0, key3 = '0;
   logic        in_ready_a, out_valid_a, busy_a, in_ready_b, out_valid_b, busy_b;
   logic [63:0] plaintext_a, plaintext_b;
   int          vecs = 0, errs = 0;

   always #5 clk = ~clk;

   tripledes_decrypt_seq #(.THREE_KEY(1'b0)) u_dut2k (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
      .ciphertext(ciphertext), .key1(key1), .key2(key2), .key3(key3),
      .out_valid(out_valid_a), .out_ready(out_ready), .plaintext(plaintext_a), .busy(busy_a));

   tripledes_decrypt_seq #(.THREE_KEY(1'b1)) u_dut3k (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
      .ciphertext(ciphertext), .key1(key1), .key2(key2), .key3(key3),
      .out_valid(out_valid_b), .out_ready(out_ready), .plaintext(plaintext_b), .busy(busy_b));

   localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                                61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
   localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
   localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                               16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
   localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
   localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                 19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
   localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                 41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
   // S-boxes in decimal, 8 boxes x 4 rows x 16 columns.
   localparam int S_T [512] = '{
      14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,     0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,     15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
      15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,     3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,     13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
      10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,     13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,     1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
      7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,     13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,     3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
      2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,     14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,     11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
      12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,     10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,     4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
      4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,     13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,     6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
      13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,     1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,     2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

   function automatic logic [63:0] des_ref(input logic [63:0] blk, input logic [63:0] key,
                                           input bit enc);
      logic [55:0] cd;
      logic [27:0] c, d;
      logic [47:0] sk [16];
      logic [47:0] x;
      logic [63:0] v, o;
      logic [31:0] l, r, f, sv;
      int sh, row, col;
      for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
      c = cd[55:28];
      d = cd[27:0];
      for (int rd = 0; rd < 16; rd++) begin
         sh = (rd == 0 || rd == 1 || rd == 8 || rd == 15) ? 1 : 2;
         c = (c << sh) | (c >> (28 - sh));
         d = (d << sh) | (d >> (28 - sh));
         cd = {c, d};
         for (int i = 0; i < 48; i++) sk[rd][47-i] = cd[56-PC2_T[i]];
      end
      for (int i = 0; i < 64; i++) v[63-i] = blk[64-IP_T[i]];
      l = v[63:32];
      r = v[31:0];
      for (int rd = 0; rd < 16; rd++) begin
         for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
         x = x ^ (enc ? sk[rd] : sk[15-rd]);
         for (int j = 0; j < 8; j++) begin
            row = 2 * int'(x[47-6*j]) + int'(x[42-6*j]);
            col = int'(x[46-6*j -: 4]);
            sv[31-4*j -: 4] = 4'(S_T[j*64 + row*16 + col]);
         end
         for (int i = 0; i < 32; i++) f[31-i] = sv[32-P_T[i]];
         f = f ^ l;
         l = r;
         r = f;
      end
      v = {r, l};
      for (int i = 0; i < 64; i++) o[63-i] = v[64-FP_T[i]];
      return o;
   endfunction

   // E(k1)-D(k2)-E(k3) and its inverse with the first-pass key named explicitly.
   function automatic logic [63:0] tdes_enc(input logic [63:0] p, k1, k2, k3);
      return des_ref(des_ref(des_ref(p, k1, 1'b1), k2, 1'b0), k3, 1'b1);
   endfunction
   function automatic logic [63:0] tdes_dec(input logic [63:0] c, kfirst, k2, klast);
      return des_ref(des_ref(des_ref(c, kfirst, 1'b0), k2, 1'b1), klast, 1'b0);
   endfunction

   function automatic logic [63:0] r64();
      return {$urandom, $urandom};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // All bench activity runs 1 time unit after a rising edge.
   task automatic send(input logic [63:0] ct, k1, k2, k3);
      int n = 0;
      while (!in_ready_a && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) chk("accept_timeout", 64'(in_ready_a), 64'd1);
      ciphertext = ct; key1 = k1; key2 = k2; key3 = k3;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic recv(output logic [63:0] pa, pb, output int lat);
      lat = 0;
      while (!out_valid_a && lat < 40) begin @(posedge clk); #1; lat++; end
      chk("ov_3k", 64'(out_valid_b), 64'd1);
      pa = plaintext_a;
      pb = plaintext_b;
   endtask

   task automatic xfer(input string tag, input logic [63:0] ct, k1, k2, k3, exp_a, exp_b);
      logic [63:0] pa, pb;
      int lat;
      send(ct, k1, k2, k3);
      chk({tag, "_busy"}, 64'(busy_a), 64'd1);
      recv(pa, pb, lat);
      chk({tag, "_lat"}, 64'(lat), 64'd3);
      chk({tag, "_pt2k"}, pa, exp_a);
      chk({tag, "_pt3k"}, pb, exp_b);
      @(posedge clk); #1;
      chk({tag, "_ready"}, 64'(in_ready_a), 64'd1);
      chk({tag, "_idle"}, 64'(busy_a), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] k1, k2, k3, p, ct, ct2, pa, pb, exp1;
      int lat;

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready_a), 64'd1);
      chk("rst_out_valid", 64'(out_valid_a), 64'd0);
      chk("rst_busy", 64'(busy_a), 64'd0);
      chk("rst_plaintext", plaintext_a, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Known single-DES vector (all keys equal).
      k1 = 64'h133457799BBCDFF1;
      xfer("kat", 64'h85E813540F0AB405, k1, k1, k1, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF);

      // Round trip with the two-key encryptor.
      k1 = 64'h0123456789ABCDEF; k2 = 64'h23456789ABCDEF01; k3 = r64();
      p  = 64'h4E6F772069732074;
      ct = tdes_enc(p, k1, k2, k1);
      xfer("rt2k", ct, k1, k2, k3, p, tdes_dec(ct, k3, k2, k1));

      // Three distinct keys, then key1/key3 swapped.
      k1 = r64(); k2 = r64(); k3 = r64(); p = r64();
      ct = tdes_enc(p, k1, k2, k3);
      xfer("rt3k", ct, k1, k2, k3, tdes_dec(ct, k1, k2, k1), p);
      send(ct, k3, k2, k1);
      recv(pa, pb, lat);
      chk("swap_3k", pb, tdes_dec(ct, k1, k2, k3));
      chk("swap_differs", 64'(pb == p), 64'd0);
      @(posedge clk); #1;

      // Random blocks with idle gaps.
      for (int t = 0; t < 12; t++) begin
         k1 = r64(); k2 = r64(); k3 = r64(); p = r64();
         ct = tdes_enc(p, k1, k2, k3);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #0;
         xfer($sformatf("rnd%0d", t), ct, k1, k2, k3, tdes_dec(ct, k1, k2, k1), p);
      end

      // Inputs churn every cycle while the block is running.
      k1 = r64(); k2 = r64(); k3 = r64(); p = r64();
      ct = tdes_enc(p, k1, k2, k3);
      send(ct, k1, k2, k3);
      repeat (3) begin
         ciphertext = r64(); key1 = r64(); key2 = r64(); key3 = r64();
         @(posedge clk); #1;
      end
      chk("churn_ov", 64'(out_valid_a), 64'd1);
      chk("churn_pt2k", plaintext_a, tdes_dec(ct, k1, k2, k1));
      chk("churn_pt3k", plaintext_b, p);
      @(posedge clk); #1;

      // Backpressure: stall in DONE while a second block waits.
      out_ready = 1'b0;
      k1 = r64(); k2 = r64(); k3 = r64();
      ct = r64();
      exp1 = tdes_dec(ct, k1, k2, k1);
      send(ct, k1, k2, k3);
      recv(pa, pb, lat);
      chk("bp_lat", 64'(lat), 64'd3);
      chk("bp_pt1", pa, exp1);
      ct2 = r64();
      ciphertext = ct2; key1 = k3; key2 = k1; key3 = k2;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_hold_pt", plaintext_a, exp1);
         chk("bp_hold_ov", 64'(out_valid_a), 64'd1);
         chk("bp_hold_ir", 64'(in_ready_a), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_consume_ir", 64'(in_ready_a), 64'd1);
      chk("bp_consume_ov", 64'(out_valid_a), 64'd0);
      chk("bp_consume_busy", 64'(busy_a), 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_accept_busy", 64'(busy_a), 64'd1);
      chk("bp_accept_ir", 64'(in_ready_a), 64'd0);
      recv(pa, pb, lat);
      chk("bp2_lat", 64'(lat), 64'd3);
      chk("bp2_pt2k", pa, tdes_dec(ct2, k3, k1, k3));
      chk("bp2_pt3k", pb, tdes_dec(ct2, k2, k1, k3));
      @(posedge clk); #1;

      // Reset while pass 1 is in progress.
      k1 = r64(); k2 = r64(); k3 = r64();
      send(r64(), k1, k2, k3);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort_ov", 64'(out_valid_a), 64'd0);
      chk("abort_ir", 64'(in_ready_a), 64'd1);
      chk("abort_busy", 64'(busy_a), 64'd0);
      chk("abort_pt2k", plaintext_a, 64'd0);
      chk("abort_pt3k", plaintext_b, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      p = r64();
      ct = tdes_enc(p, k1, k2, k3);
      xfer("post_rst", ct, k1, k2, k3, tdes_dec(ct, k1, k2, k1), p);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
